fpu_share_arbiter: RTL and testbench
====================================

// Module: fpu_share_arbiter
// PURPOSE
//  Shares one fpnew_top instance between N_REQ requesters (e.g. issue stage, vector/debug port).
//  Round-robin grant with one op in flight; the FPU tag carries the requester index.
//  Routes each result back to its requester. A watchdog converts a hung FPU op into an error response.
// PARAMETERS
//  N_REQ    2    number of requesters, >=2
//  PLD_W    200  opaque request payload width (operands, op, fmt, rnd_mode)
//  RES_W    64   result width
//  TIMEOUT  64   max cycles in WAIT before abort, >=2
// PORTS
//  clk_i              in   1            clock
//  rst_ni             in   1            async reset, active low
//  req_valid_i        in   N_REQ        per-requester request valid
//  req_ready_o        out  N_REQ        per-requester accept (one-hot or zero)
//  req_payload_i      in   N_REQ*PLD_W  per-requester payload, slice i = requester i
//  flush_i            in   1            abort any op in flight, no response
//  fpu_valid_o        out  1            op valid toward FPU
//  fpu_ready_i        in   1            FPU accepts op
//  fpu_payload_o      out  PLD_W        latched payload of granted requester
//  fpu_tag_o          out  clog2(N_REQ) granted requester index
//  fpu_flush_o        out  1            one-cycle flush pulse to FPU
//  fpu_out_valid_i    in   1            FPU result valid
//  fpu_result_i       in   RES_W        FPU result
//  fpu_status_i       in   5            FPU flags {NV,DZ,OF,UF,NX}
//  rsp_valid_o        out  N_REQ        response valid, one-hot or zero
//  rsp_ready_i        in   N_REQ        per-requester response accept
//  rsp_result_o       out  RES_W        captured result (0 on timeout)
//  rsp_status_o       out  5            captured flags (0 on timeout)
//  rsp_err_o          out  1            1 = op aborted by watchdog
//  busy_o             out  1            state != IDLE
// BEHAVIOUR
//  - Reset (rst_ni low, asynchronous): state=IDLE, rr_ptr=0, counter=0, all outputs 0.
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are decoded from registered state/latches.
//    Exception: req_ready_o is combinational.
//  - IDLE: grant = first valid index scanning rr_ptr, rr_ptr+1 .. (mod N_REQ).
//    req_ready_o[grant]=1 in the same cycle, only when !flush_i. Latch payload and tag; go ISSUE.
//    Set rr_ptr <= (grant+1) mod N_REQ.
//  - ISSUE: fpu_valid_o=1, payload/tag held stable until fpu_ready_i.
//    On handshake go WAIT with counter=0. Accept-to-fpu_valid_o latency is 1 cycle.
//  - WAIT: counter++ each cycle.
//    On fpu_out_valid_i: latch result/status, err=0, go RESP.
//    On counter==TIMEOUT-1 without result: result=0, status=0, err=1, pulse fpu_flush_o, go RESP.
//    If result and timeout fall in the same cycle, the result wins (err=0, no flush).
//  - RESP: rsp_valid_o[tag]=1 with data held stable until rsp_ready_i[tag]; then go IDLE.
//    A new grant is possible in the cycle after IDLE is entered.
//  - flush_i in ISSUE or WAIT: next state IDLE and fpu_flush_o=1 for 1 cycle.
//    flush_i in RESP: response dropped, next state IDLE, no fpu_flush_o.
//    flush_i in IDLE: no grant that cycle.
//  - fpu_out_valid_i outside WAIT is stale and is ignored (dropped).
//  - rr_ptr advances only on a grant; a flushed or timed-out op still advances it.
// TESTING
//  1 N_REQ=2, both req_valid_i=1 continuously, FPU returns in 3 cycles
//    -> grants alternate 0,1,0,1; tags match; rsp_valid_o only on the granted index.
//  2 Single request, fpu_ready_i held 0 for 5 cycles
//    -> fpu_valid_o stays 1 with a stable payload; WAIT is entered on the cycle after the handshake.
//  3 FPU never responds, TIMEOUT=64
//    -> 64 cycles in WAIT, then fpu_flush_o pulses once; rsp_err_o=1 and rsp_result_o=0 on the response.
//  4 fpu_out_valid_i=1 with result 0x3FF0000000000000 on the timeout cycle
//    -> rsp_err_o=0, result delivered, fpu_flush_o stays 0.
//  5 flush_i in WAIT cycle 2; stale fpu_out_valid_i arrives 3 cycles later
//    -> no rsp_valid_o, fpu_flush_o pulses once, busy_o=0 next cycle, stale result ignored.
//  6 rsp_ready_i held 0 for 10 cycles, then rst_ni asserted in WAIT of the next op
//    -> response data stable until accepted; on reset all outputs are 0 immediately and rr_ptr=0.

Source files
------------

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one FPU between N_REQ requesters,
// one op in flight, result routed back by tag, watchdog turns hung ops into errors.
module fpu_share_arbiter #(
  parameter int N_REQ   = 2,
  parameter int PLD_W   = 200,
  parameter int RES_W   = 64,
  parameter int TIMEOUT = 64,
  localparam int TW     = $clog2(N_REQ),
  localparam int CW     = $clog2(TIMEOUT)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*PLD_W-1:0] req_payload_i,
  input  logic                   flush_i,
  output logic                   fpu_valid_o,
  input  logic                   fpu_ready_i,
  output logic [PLD_W-1:0]       fpu_payload_o,
  output logic [TW-1:0]          fpu_tag_o,
  output logic                   fpu_flush_o,
  input  logic                   fpu_out_valid_i,
  input  logic [RES_W-1:0]       fpu_result_i,
  input  logic [4:0]             fpu_status_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  input  logic [N_REQ-1:0]       rsp_ready_i,
  output logic [RES_W-1:0]       rsp_result_o,
  output logic [4:0]             rsp_status_o,
  output logic                   rsp_err_o,
  output logic                   busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [TW-1:0] rr_q, rr_d, tag_q, tag_d, gnt, cand;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PLD_W-1:0] pld_q, pld_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [4:0] st_q, st_d;
  logic err_q, err_d, flush_q, flush_d, gnt_vld;
  // scan from the highest offset down so the lowest offset from rr_q wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = TW'((int'(rr_q) + k) % N_REQ);
      if (req_valid_i[cand]) begin
        gnt_vld = 1'b1;
        gnt = cand;
      end
    end
  end
  assign req_ready_o = (rst_ni && state_q == IDLE && !flush_i && gnt_vld) ? N_REQ'(1) << gnt : '0;
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    tag_d = tag_q;
    cnt_d = cnt_q;
    pld_d = pld_q;
    res_d = res_q;
    st_d = st_q;
    err_d = err_q;
    flush_d = 1'b0;
    case (state_q)
      IDLE: if (req_ready_o != '0) begin
        state_d = ISSUE;
        tag_d = gnt;
        pld_d = req_payload_i[gnt*PLD_W +: PLD_W];
        rr_d = (gnt == TW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
      end
      ISSUE: if (flush_i) begin
        state_d = IDLE;
        flush_d = 1'b1;
      end else if (fpu_ready_i) begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: if (flush_i) begin
        state_d = IDLE;
        flush_d = 1'b1;
      end else if (fpu_out_valid_i) begin
        state_d = RESP;
        res_d = fpu_result_i;
        st_d = fpu_status_i;
        err_d = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = RESP;
        res_d = '0;
        st_d = '0;
        err_d = 1'b1;
        flush_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: state_d = (flush_i || rsp_ready_i[tag_q]) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q <= '0;
      tag_q <= '0;
      cnt_q <= '0;
      pld_q <= '0;
      res_q <= '0;
      st_q <= '0;
      err_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
      pld_q <= pld_d;
      res_q <= res_d;
      st_q <= st_d;
      err_q <= err_d;
      flush_q <= flush_d;
    end
  end
  assign fpu_valid_o = state_q == ISSUE;
  assign fpu_payload_o = pld_q;
  assign fpu_tag_o = tag_q;
  assign fpu_flush_o = flush_q;
  assign rsp_valid_o = (state_q == RESP) ? N_REQ'(1) << tag_q : '0;
  assign rsp_result_o = res_q;
  assign rsp_status_o = st_q;
  assign rsp_err_o = err_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter: scoreboard bench with a behavioural FPU and response sink model.
module tb_fpu_share_arbiter;
  localparam int N = 2, PW = 200, RW = 64, TO = 64;
  typedef struct { int tag; logic [63:0] res; logic [4:0] st; logic err; } exp_t;
  logic clk = 1'b0, rst_ni = 1'b1;
  logic [N-1:0] req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N*PW-1:0] req_payload_i;
  logic flush_i, fpu_valid_o, fpu_ready_i, fpu_flush_o, fpu_out_valid_i, rsp_err_o, busy_o;
  logic [PW-1:0] fpu_payload_o;
  logic [0:0] fpu_tag_o;
  logic [RW-1:0] fpu_result_i, rsp_result_o;
  logic [4:0] fpu_status_i, rsp_status_o;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int gcnt = 0, fcnt = 0, wcnt = 0, rvcnt = 0, lastg = -1, rot_idx = -1;
  int ready_stall = 0, fstall = 0, lat = 3, cyc = 0, rsp_stall = 0, rstall = 0;
  int ncnt [N];
  bit pending = 0, rot = 0;
  logic [PW-1:0] hs_pld, p;

  fpu_share_arbiter #(.N_REQ(N), .PLD_W(PW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_payload_i(req_payload_i), .flush_i(flush_i), .fpu_valid_o(fpu_valid_o),
    .fpu_ready_i(fpu_ready_i), .fpu_payload_o(fpu_payload_o), .fpu_tag_o(fpu_tag_o),
    .fpu_flush_o(fpu_flush_o), .fpu_out_valid_i(fpu_out_valid_i), .fpu_result_i(fpu_result_i),
    .fpu_status_i(fpu_status_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int i, input int n);
    logic [PW-1:0] v;
    v = '0;
    v[63:0] = 64'h4000_0000_0000_0000 | (64'(i) << 40) | 64'(n);
    v[68:64] = 5'(i * 3 + n + 1);
    v[PW-1 -: 8] = 8'(i + n + 7);
    return v;
  endfunction

  task automatic push(input int t, input logic [63:0] r, input logic [4:0] s, input logic e);
    exp_t x;
    x.tag = t; x.res = r; x.st = s; x.err = e;
    sb.push_back(x);
  endtask

  task automatic monitor();
    exp_t e;
    if (!rst_ni) return;
    if ((req_valid_i & req_ready_o) != '0) begin
      gcnt++;
      lastg = (req_ready_o == 2'b10) ? 1 : 0;
      rot_idx = lastg;
    end
    if (fpu_valid_o && fpu_ready_i) begin
      pending = 1; cyc = 0; hs_pld = fpu_payload_o;
    end
    if (fpu_flush_o) fcnt++;
    if (busy_o && !fpu_valid_o && rsp_valid_o == '0) wcnt++;
    if (rsp_valid_o != '0) begin
      rvcnt++;
      if (sb.size() == 0) chk("sb_empty", rsp_valid_o, 0);
      else if ((rsp_valid_o & rsp_ready_i) != '0) begin
        e = sb.pop_front();
        chk("rsp_vld", rsp_valid_o, N'(1) << e.tag);
        chk("rsp_res", rsp_result_o, e.res);
        chk("rsp_st", rsp_status_o, e.st);
        chk("rsp_err", rsp_err_o, e.err);
      end else chk("rsp_hold", rsp_result_o, sb[0].res);
    end
  endtask

  task automatic drive_model();
    if (rot && rot_idx >= 0) begin
      ncnt[rot_idx]++;
      req_payload_i[rot_idx*PW +: PW] = mk(rot_idx, ncnt[rot_idx]);
    end
    rot_idx = -1;
    if (fpu_valid_o) begin fpu_ready_i = fstall >= ready_stall; fstall++; end
    else begin fpu_ready_i = 0; fstall = 0; end
    fpu_out_valid_i = 0;
    if (pending) begin
      cyc++;
      if (lat != 0 && cyc == lat) begin
        fpu_out_valid_i = 1; fpu_result_i = hs_pld[63:0]; fpu_status_i = hs_pld[68:64]; pending = 0;
      end
    end
    if (rsp_valid_o != '0) begin rsp_ready_i = (rstall >= rsp_stall) ? rsp_valid_o : '0; rstall++; end
    else begin rsp_ready_i = '0; rstall = 0; end
  endtask

  task automatic step();
    #1;
    monitor();
    @(posedge clk);
    #1;
    drive_model();
    @(negedge clk);
  endtask

  task automatic issue(input int i, input logic [PW-1:0] v);
    int g0 = gcnt, k = 0;
    req_payload_i[i*PW +: PW] = v;
    req_valid_i[i] = 1'b1;
    while (gcnt == g0 && k < 50) begin step(); k++; end
    req_valid_i = '0;
    chk("grant_idx", lastg, i);
  endtask

  task automatic drain();
    int k = 0;
    while ((busy_o || sb.size() != 0) && k < 300) begin step(); k++; end
    chk("drain", sb.size() + int'(busy_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int f0, r0, k;
    req_valid_i = '0; req_payload_i = '0; flush_i = 0; fpu_ready_i = 0; fpu_out_valid_i = 0;
    fpu_result_i = '0; fpu_status_i = '0; rsp_ready_i = '0;
    for (int i = 0; i < N; i++) ncnt[i] = 0;
    #1 rst_ni = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_fvld", fpu_valid_o, 0);
    chk("rst_rvld", rsp_valid_o, 0);
    chk("rst_flush", fpu_flush_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    // both requesters always valid: grants must alternate 0,1,0,1
    req_payload_i[0 +: PW] = mk(0, 0);
    req_payload_i[PW +: PW] = mk(1, 0);
    p = mk(0, 0); push(0, p[63:0], p[68:64], 0);
    p = mk(1, 0); push(1, p[63:0], p[68:64], 0);
    p = mk(0, 1); push(0, p[63:0], p[68:64], 0);
    p = mk(1, 1); push(1, p[63:0], p[68:64], 0);
    rot = 1; lat = 3; req_valid_i = 2'b11; k = 0;
    while (gcnt < 4 && k < 200) begin step(); k++; end
    req_valid_i = '0; rot = 0;
    drain();
    // FPU stalls ready for 5 cycles
    ready_stall = 5;
    p = mk(1, 10); push(1, p[63:0], p[68:64], 0);
    issue(1, p);
    for (int i = 0; i < 5; i++) begin
      chk("iss_vld", fpu_valid_o, 1);
      chk("iss_pld", fpu_payload_o, p);
      chk("iss_tag", fpu_tag_o, 1);
      step();
    end
    chk("iss_vld6", fpu_valid_o, 1);
    step();
    chk("wait_vld", fpu_valid_o, 0);
    chk("wait_busy", busy_o, 1);
    drain();
    ready_stall = 0;
    // FPU never answers: watchdog abort
    lat = 0; wcnt = 0; f0 = fcnt;
    push(0, 64'h0, 5'h0, 1);
    issue(0, mk(0, 20));
    drain();
    chk("to_wait", wcnt, TO);
    chk("to_flush", fcnt - f0, 1);
    // result lands on the timeout cycle and wins
    lat = TO; wcnt = 0; f0 = fcnt;
    p = mk(1, 30); p[63:0] = 64'h3FF0_0000_0000_0000;
    push(1, p[63:0], p[68:64], 0);
    issue(1, p);
    drain();
    chk("race_wait", wcnt, TO);
    chk("race_noflush", fcnt - f0, 0);
    // flush in WAIT cycle 2, stale result later
    lat = 0;
    issue(0, mk(0, 40));
    step();
    step();
    f0 = fcnt; r0 = rvcnt;
    flush_i = 1;
    step();
    flush_i = 0;
    chk("fl_pulse", fpu_flush_o, 1);
    chk("fl_busy", busy_o, 0);
    step();
    step();
    fpu_out_valid_i = 1; fpu_result_i = 64'hDEAD_BEEF; fpu_status_i = 5'h1f;
    step();
    chk("stale_busy", busy_o, 0);
    chk("stale_rvld", rsp_valid_o, 0);
    repeat (3) step();
    chk("fl_once", fcnt - f0, 1);
    chk("fl_norsp", rvcnt - r0, 0);
    // response held 10 cycles, then reset mid-WAIT of next op
    rsp_stall = 10; lat = 2; r0 = rvcnt;
    p = mk(1, 50); push(1, p[63:0], p[68:64], 0);
    issue(1, p);
    drain();
    chk("rsp_stall_len", rvcnt - r0, 11);
    rsp_stall = 0; lat = 0;
    issue(0, mk(0, 60));
    step();
    step();
    chk("pre_rst_busy", busy_o, 1);
    req_valid_i = 2'b11;
    rst_ni = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_fvld", fpu_valid_o, 0);
    chk("arst_pld", fpu_payload_o, 0);
    chk("arst_tag", fpu_tag_o, 0);
    chk("arst_flush", fpu_flush_o, 0);
    chk("arst_rvld", rsp_valid_o, 0);
    chk("arst_res", rsp_result_o, 0);
    chk("arst_st", rsp_status_o, 0);
    chk("arst_err", rsp_err_o, 0);
    chk("arst_rdy", req_ready_o, 0);
    pending = 0; fpu_ready_i = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rr_reset", req_ready_o, 2'b01);
    req_valid_i = '0;
    step();
    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
